riscv_mem_arbiter: RTL

//  Shares the single-port unified program/data memory between instruction fetch (IF) and load/store (LSU).

---
 rtl/riscv_pkg.sv | 19 +
 rtl/riscv_mem_arb_perf.sv | 39 +++
 rtl/riscv_mem_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared types for the unified-memory arbiter.
//   XLEN         default data/address width
//   arb_state_t  arbiter FSM state (ARB_IDLE, ARB_WAIT)
//   arb_owner_t  which requester owns the access in flight (OWN_IF, OWN_LSU)
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/riscv_mem_arb_perf.sv
// riscv_mem_arb_perf -- arbiter performance counters (32-bit, wrap-around).
// Only instantiated when ARB_PERF_CNT_EN is defined.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (clears counters)
//   if_stall          IF is requesting but not granted this cycle
//   lsu_grant         LSU granted this cycle
//   perf_if_stall     count of if_stall cycles
//   perf_lsu_grants   count of LSU grants
module riscv_mem_arb_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stall,
  input  logic        lsu_grant,
  output logic [31:0] perf_if_stall,
  output logic [31:0] perf_lsu_grants
);

  logic [1:0]  inc;
  logic [31:0] cnt_reg [2];

  assign inc = {lsu_grant, if_stall};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (inc[gi]) begin
          cnt_reg[gi] <= cnt_reg[gi] + 32'd1;
        end
      end
    end
  endgenerate

  assign perf_if_stall   = cnt_reg[0];
  assign perf_lsu_grants = cnt_reg[1];

endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter -- shares one single-port program/data memory between
// instruction fetch (IF) and load/store (LSU). One access in flight at a time.
// LSU has priority; after MAX_STREAK consecutive LSU wins with IF waiting, IF wins.
// Optional feature macro: ARB_PERF_CNT_EN (perf counters; tied to 0 otherwise).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_req/if_addr           IF read request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata IF grant pulse, data-valid pulse, data (0 when invalid)
//   lsu_req/addr/we/wdata/be LSU request, held until lsu_gnt
//   lsu_gnt/lsu_rvalid/lsu_rdata LSU grant, completion pulse, load data (0 on store ack)
//   mem_en/we/addr/wdata/be  memory strobe and command, driven in the grant cycle
//   mem_rdata                memory read data, valid MEM_LAT cycles after mem_en
//   perf_if_stall            cycles IF requested without grant
//   perf_lsu_grants          LSU grants issued
module riscv_mem_arbiter #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            lsu_req,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic            lsu_we,
  input  logic [XLEN-1:0] lsu_wdata,
  input  logic [3:0]      lsu_be,
  output logic            lsu_gnt,
  output logic            lsu_rvalid,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [31:0]     perf_if_stall,
  output logic [31:0]     perf_lsu_grants
);
  import riscv_pkg::*;

  localparam int LCW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam int SCW = (MAX_STREAK < 2) ? 1 : $clog2(MAX_STREAK + 1);

  arb_state_t     state_reg;
  arb_owner_t     owner_reg;
  logic           load_reg;     // access in flight returns data (IF or LSU load)
  logic [LCW-1:0] lat_cnt_reg;
  logic [SCW-1:0] streak_reg;

  logic done;
  logic arb_ok;
  logic starve;
  logic lsu_win;
  logic if_win;

  // Completion cycle doubles as an arbitration slot, giving one access per MEM_LAT cycles.
  assign done   = (state_reg == ARB_WAIT) && (lat_cnt_reg == LCW'(1));
  assign arb_ok = (state_reg == ARB_IDLE) || done;
  assign starve = if_req && (streak_reg == SCW'(MAX_STREAK));

  // Grants are combinational, so gate them with rst to keep every output 0 in reset.
  assign lsu_win = !rst && arb_ok && lsu_req && !starve;
  assign if_win  = !rst && arb_ok && if_req && !lsu_win;

  assign if_gnt    = if_win;
  assign lsu_gnt   = lsu_win;
  assign mem_en    = if_win || lsu_win;
  assign mem_we    = lsu_win && lsu_we;
  assign mem_addr  = lsu_win ? lsu_addr : (if_win ? if_addr : '0);
  assign mem_wdata = lsu_win ? lsu_wdata : '0;
  assign mem_be    = lsu_win ? lsu_be : (if_win ? 4'hF : 4'h0);

  assign if_rvalid  = done && (owner_reg == OWN_IF);
  assign if_rdata   = if_rvalid ? mem_rdata : '0;
  assign lsu_rvalid = done && (owner_reg == OWN_LSU);
  assign lsu_rdata  = (lsu_rvalid && load_reg) ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ARB_IDLE;
      owner_reg   <= OWN_IF;
      load_reg    <= 1'b0;
      lat_cnt_reg <= '0;
      streak_reg  <= '0;
    end else begin
      if (mem_en) begin
        state_reg   <= ARB_WAIT;
        owner_reg   <= lsu_win ? OWN_LSU : OWN_IF;
        load_reg    <= if_win || !lsu_we;
        lat_cnt_reg <= LCW'(MEM_LAT);
      end else if (done) begin
        state_reg   <= ARB_IDLE;
        lat_cnt_reg <= '0;
      end else if (state_reg == ARB_WAIT) begin
        lat_cnt_reg <= lat_cnt_reg - LCW'(1);
      end

      // Streak only counts LSU wins that made IF wait; any other arbitration clears it.
      if (arb_ok) begin
        if (lsu_win && if_req) begin
          if (streak_reg != SCW'(MAX_STREAK)) begin
            streak_reg <= streak_reg + SCW'(1);
          end
        end else begin
          streak_reg <= '0;
        end
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  riscv_mem_arb_perf u_perf (
    .clk             (clk),
    .rst             (rst),
    .if_stall        (if_req && !if_win),
    .lsu_grant       (lsu_win),
    .perf_if_stall   (perf_if_stall),
    .perf_lsu_grants (perf_lsu_grants)
  );
`else
  assign perf_if_stall   = 32'd0;
  assign perf_lsu_grants = 32'd0;
`endif

endmodule
